// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings for the LED pattern sequencer
package led_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} dir_t;
  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_ROT    = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;
endpackage

// File: rtl/led_pattern_sequencer_btn_sync_edge.sv
// btn_sync_edge: synchronizes the raw run button and emits a one-cycle press pulse on its rising edge
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_btn,
  output logic press
);
  logic [SYNC_STAGES-1:0] chain;
  logic sync_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain  <= '0;
      sync_d <= 1'b0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], run_btn};
      sync_d <= chain[SYNC_STAGES-1];
    end
  end
  assign press = chain[SYNC_STAGES-1] & ~sync_d;
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps an LED pattern once per tick with run/pause, clear and four pattern modes
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             run_btn,
  input  logic             clr,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             running,
  output logic             step_done
);
  state_t state, next_state;
  dir_t dir, next_dir;
  logic [1:0] mode_q;
  logic press, step, load;
  logic [WIDTH-1:0] stepped, seed;
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
    .clk(clk),
    .rst(rst),
    .run_btn(run_btn),
    .press(press)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end
  always_comb begin
    next_state = state;
    if (clr) next_state = IDLE;
    else if (press) next_state = (state == IDLE) ? RUN : (state == RUN) ? PAUSE : RUN;
  end
  assign step = (state == RUN) && tick && !clr;
  assign load = (state == IDLE) && press && !clr;
  always_comb begin
    seed = (mode == MODE_UP) ? '0 : (mode == MODE_DOWN) ? '1 : WIDTH'(1);
    stepped = (mode_q == MODE_UP)   ? out + WIDTH'(1) :
              (mode_q == MODE_DOWN) ? out - WIDTH'(1) :
              (mode_q == MODE_ROT)  ? {out[WIDTH-2:0], out[WIDTH-1]} :
              (dir == LEFT)         ? out << 1 : out >> 1;
    // Bounce turns around on the step that lands on an end, so each end shows once
    next_dir = dir;
    if (mode_q == MODE_BOUNCE && dir == LEFT && stepped[WIDTH-1]) next_dir = RIGHT;
    if (mode_q == MODE_BOUNCE && dir == RIGHT && stepped[0]) next_dir = LEFT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      running   <= 1'b0;
      step_done <= 1'b0;
      dir       <= LEFT;
      mode_q    <= MODE_UP;
    end else begin
      running   <= (next_state == RUN);
      step_done <= step;
      if (clr) begin
        out <= '0;
        dir <= LEFT;
      end else if (load) begin
        mode_q <= mode;
        out    <= seed;
        dir    <= LEFT;
      end else if (step) begin
        out <= stepped;
        dir <= next_dir;
      end
    end
  end
endmodule
